// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a wait-stated word memory and the MEM/WB register.
// Accesses complete on the first edge where Stall is low; stalled edges load bubbles.
module mem_stage #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  WB_in,
  input  logic [2:0]  M_in,
  input  logic [31:0] ALU_in,
  input  logic        Zero_in,
  input  logic [31:0] ADD_in,
  input  logic [31:0] B_in,
  input  logic [4:0]  MUX_in,
  output logic        PCSrc,
  output logic [31:0] Branch_target,
  output logic        Stall,
  output logic [1:0]  WB_out,
  output logic [31:0] Read_data_out,
  output logic [31:0] ALU_out,
  output logic [4:0]  MUX_out,
  output logic        Addr_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t        state;
  logic [3:0]    cnt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          memop, misal, done;
  logic          unused_ok;
  assign idx           = ALU_in[AW+1:2];
  assign memop         = M_in[1] | M_in[0];
  assign misal         = |ALU_in[1:0];
  assign PCSrc         = M_in[2] & Zero_in;
  assign Branch_target = ADD_in;
  assign Stall         = reset & ((state == IDLE) ? (memop && (WAIT_STATES != 0)) : (cnt != 4'd0));
  assign done          = reset & ~Stall;
  assign unused_ok     = ^ALU_in[31:AW+2];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      WB_out        <= '0;
      Read_data_out <= '0;
      ALU_out       <= '0;
      MUX_out       <= '0;
      Addr_err      <= 1'b0;
    end else if (Stall) begin
      state         <= WAIT;
      cnt           <= (state == IDLE) ? 4'(WAIT_STATES - 1) : cnt - 4'd1;
      WB_out        <= '0;
      Read_data_out <= '0;
      ALU_out       <= '0;
      MUX_out       <= '0;
      Addr_err      <= 1'b0;
    end else begin
      state         <= IDLE;
      cnt           <= '0;
      WB_out        <= WB_in;
      Read_data_out <= (M_in[1] && !M_in[0] && !misal) ? mem[idx] : '0;
      ALU_out       <= ALU_in;
      MUX_out       <= MUX_in;
      Addr_err      <= memop & misal;
    end
  // Memory is never cleared by reset; done is low during reset so no write slips through.
  always_ff @(posedge clk)
    if (done && M_in[0] && !misal) mem[idx] <= B_in;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a queue scoreboard against a WAIT_STATES=2 instance,
// plus a zero-wait instance sharing the same inputs.
module tb_mem_stage;
  logic        clk = 1'b0, reset = 1'b0;
  logic [1:0]  WB_in;
  logic [2:0]  M_in;
  logic [31:0] ALU_in, ADD_in, B_in;
  logic        Zero_in;
  logic [4:0]  MUX_in;
  logic        PCSrc, Stall, Addr_err;
  logic [31:0] Branch_target, Read_data_out, ALU_out;
  logic [1:0]  WB_out;
  logic [4:0]  MUX_out;
  logic        z_pcsrc, z_stall, z_err;
  logic [31:0] z_bt, z_rd, z_alu;
  logic [1:0]  z_wb;
  logic [4:0]  z_mux;
  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  mux;
    logic        err;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int   checks = 0, failures = 0;
  logic busy = 1'b0, pb = 1'b0, ps = 1'b0;

  mem_stage #(.DEPTH(256), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .WB_in(WB_in), .M_in(M_in), .ALU_in(ALU_in), .Zero_in(Zero_in),
    .ADD_in(ADD_in), .B_in(B_in), .MUX_in(MUX_in), .PCSrc(PCSrc), .Branch_target(Branch_target),
    .Stall(Stall), .WB_out(WB_out), .Read_data_out(Read_data_out), .ALU_out(ALU_out),
    .MUX_out(MUX_out), .Addr_err(Addr_err));

  mem_stage #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .WB_in(WB_in), .M_in(M_in), .ALU_in(ALU_in), .Zero_in(Zero_in),
    .ADD_in(ADD_in), .B_in(B_in), .MUX_in(MUX_in), .PCSrc(z_pcsrc), .Branch_target(z_bt),
    .Stall(z_stall), .WB_out(z_wb), .Read_data_out(z_rd), .ALU_out(z_alu),
    .MUX_out(z_mux), .Addr_err(z_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nop();
    WB_in = '0; M_in = '0; ALU_in = '0; ADD_in = '0; B_in = '0; Zero_in = 1'b0; MUX_in = '0;
  endtask

  // Holds one operation on the inputs until its completing edge; called just after a rising edge.
  task automatic issue(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                       input logic [31:0] b, input logic [4:0] mux, input logic [31:0] rd,
                       input logic err, input int stalls);
    int n = 0;
    bit fin = 1'b0;
    WB_in = wb; M_in = m; ALU_in = alu; B_in = b; MUX_in = mux;
    q.push_back('{wb, rd, alu, mux, err});
    busy = 1'b1;
    for (int i = 0; i < 20 && !fin; i++) begin
      @(negedge clk);
      if (Stall) n++;
      else fin = 1'b1;
    end
    if (!fin) begin
      failures++;
      $display("FAIL stall_timeout: Stall still 1 after 20 cycles, required 0");
    end
    chk("stall_cycles", 32'(n), 32'(stalls));
    @(posedge clk);
    #1;
    busy = 1'b0;
    nop();
  endtask

  // Monitor: result of each edge is judged at the following falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        pb = 1'b0;
        ps = 1'b0;
      end else begin
        chk("z_stall", 32'(z_stall), 32'd0);
        if (pb && !ps) begin
          if (q.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: result presented with no expected entry");
          end else begin
            e = q.pop_front();
            chk("wb_out", 32'(WB_out), 32'(e.wb));
            chk("read_data", Read_data_out, e.rd);
            chk("alu_out", ALU_out, e.alu);
            chk("mux_out", 32'(MUX_out), 32'(e.mux));
            chk("addr_err", 32'(Addr_err), 32'(e.err));
          end
        end else if (pb) begin
          chk("bubble_wb", 32'(WB_out), 32'd0);
          chk("bubble_rd", Read_data_out, 32'd0);
          chk("bubble_alu", ALU_out, 32'd0);
          chk("bubble_mux", 32'(MUX_out), 32'd0);
          chk("bubble_err", 32'(Addr_err), 32'd0);
        end else
          chk("idle_err", 32'(Addr_err), 32'd0);
        pb = busy;
        ps = Stall;
      end
    end
  end

  initial begin
    nop();
    M_in = 3'b001;
    ALU_in = 32'h10;
    #12;
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_wb", 32'(WB_out), 32'd0);
    chk("rst_rd", Read_data_out, 32'd0);
    chk("rst_alu", ALU_out, 32'd0);
    chk("rst_mux", 32'(MUX_out), 32'd0);
    chk("rst_err", 32'(Addr_err), 32'd0);
    nop();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    issue(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 2);
    issue(2'b11, 3'b010, 32'h10, 32'h0, 5'd5, 32'hDEADBEEF, 1'b0, 2);
    chk("z_load", z_rd, 32'hDEADBEEF);
    issue(2'b10, 3'b000, 32'h7, 32'h0, 5'd9, 32'h0, 1'b0, 0);
    chk("z_rtype_wb", 32'(z_wb), 32'd2);
    chk("z_rtype_alu", z_alu, 32'h7);
    chk("z_rtype_mux", 32'(z_mux), 32'd9);
    chk("z_rtype_rd", z_rd, 32'h0);
    M_in = 3'b100; Zero_in = 1'b1; ADD_in = 32'h40;
    #1;
    chk("pcsrc_taken", 32'(PCSrc), 32'd1);
    chk("branch_target", Branch_target, 32'h40);
    Zero_in = 1'b0;
    #1;
    chk("pcsrc_not_taken", 32'(PCSrc), 32'd0);
    M_in = 3'b000; Zero_in = 1'b1;
    #1;
    chk("pcsrc_no_branch", 32'(PCSrc), 32'd0);
    nop();
    @(posedge clk); #1;
    issue(2'b00, 3'b001, 32'h13, 32'h12345678, 5'd0, 32'h0, 1'b1, 2);
    issue(2'b11, 3'b010, 32'h10, 32'h0, 5'd1, 32'hDEADBEEF, 1'b0, 2);
    issue(2'b11, 3'b010, 32'h11, 32'h0, 5'd3, 32'h0, 1'b1, 2);
    issue(2'b00, 3'b001, 32'h400, 32'hCAFEF00D, 5'd0, 32'h0, 1'b0, 2);
    issue(2'b11, 3'b010, 32'h0, 32'h0, 5'd2, 32'hCAFEF00D, 1'b0, 2);
    issue(2'b11, 3'b010, 32'h410, 32'h0, 5'd4, 32'hDEADBEEF, 1'b0, 2);
    issue(2'b11, 3'b011, 32'h20, 32'h55AA55AA, 5'd6, 32'h0, 1'b0, 2);
    issue(2'b11, 3'b010, 32'h20, 32'h0, 5'd7, 32'h55AA55AA, 1'b0, 2);
    issue(2'b00, 3'b001, 32'h30, 32'h11111111, 5'd0, 32'h0, 1'b0, 2);
    WB_in = 2'b00; M_in = 3'b001; ALU_in = 32'h30; B_in = 32'h99999999;
    busy = 1'b1;
    @(posedge clk); #3;
    chk("wait_stall", 32'(Stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_stall", 32'(Stall), 32'd0);
    chk("midrst_wb", 32'(WB_out), 32'd0);
    chk("midrst_rd", Read_data_out, 32'd0);
    chk("midrst_err", 32'(Addr_err), 32'd0);
    busy = 1'b0;
    nop();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    issue(2'b11, 3'b010, 32'h30, 32'h0, 5'd8, 32'h11111111, 1'b0, 2);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("async_wb", 32'(WB_out), 32'd0);
    chk("async_rd", Read_data_out, 32'd0);
    chk("async_alu", ALU_out, 32'd0);
    chk("async_mux", 32'(MUX_out), 32'd0);
    chk("sb_drained", 32'(q.size()), 32'd0);
    #10;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
